// File: rtl/fp32_adder_pkg.sv
// Shared types and constants for the single-precision adder.
package fp32_adder_pkg;

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1,
    NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MIN  = -126;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic                sign;
    logic signed [9:0]   exp;
    logic [23:0]         mant;
    logic                is_nan;
    logic                is_inf;
    logic                is_zero;
  } fp_fields_t;

endpackage

// File: rtl/fp32_unpack.sv
// Field split of one fp32 operand. With FP32_ADDER_DENORM_EN undefined,
// denormals report as zero so they take the signed-zero path.
module fp32_unpack
  import fp32_adder_pkg::*;
(
  input  logic [31:0] val,
  output fp_fields_t  f
);

  logic [7:0]  e;
  logic [22:0] frac;

  always_comb begin
    e         = val[30:23];
    frac      = val[22:0];
    f.sign    = val[31];
    f.exp     = (e == 8'd0) ? 10'(EXP_MIN) : $signed({2'b00, e}) - 10'sd127;
    f.mant    = {e != 8'd0, frac};
    f.is_nan  = (e == 8'hFF) && (frac != 23'd0);
    f.is_inf  = (e == 8'hFF) && (frac == 23'd0);
`ifdef FP32_ADDER_DENORM_EN
    f.is_zero = (e == 8'd0) && (frac == 23'd0);
`else
    f.is_zero = (e == 8'd0);
`endif
  end

endmodule

// File: rtl/fp32_adder.sv
// Iterative fp32 adder with strobe/ack operand handshake and one-cycle result strobe.
// FP32_ADDER_DENORM_EN enables denormal inputs/results; otherwise they flush to signed zero.
module fp32_adder
  import fp32_adder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb
);

  localparam logic signed [9:0] E_MIN  = 10'(EXP_MIN);
  localparam logic signed [9:0] E_MAX  = 10'(EXP_BIAS);
  localparam logic signed [9:0] E_BIAS = 10'(EXP_BIAS);

  state_t            state;
  logic [31:0]       a, b, z;
  fp_fields_t        fa, fb;
  logic [26:0]       a_m, b_m, z_m;
  logic signed [9:0] a_e, b_e, z_e;
  logic              a_s, b_s, z_s;
  logic [27:0]       sum;
  logic [7:0]        z_exp_field;
  logic [31:0]       z_packed;

  fp32_unpack u_unpack_a (.val(a), .f(fa));
  fp32_unpack u_unpack_b (.val(b), .f(fb));

  always_comb begin
    z_exp_field = 8'(z_e + E_BIAS);
    z_packed    = {z_s, z_exp_field, z_m[25:3]};
    if (z_e == E_MIN && !z_m[26]) begin
`ifdef FP32_ADDER_DENORM_EN
      z_packed[30:23] = 8'd0;
`else
      z_packed = {z_s, 31'd0};
`endif
    end
    if (z_e > E_MAX) z_packed = POS_INF | {z_s, 31'd0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z     <= 32'd0;
      output_z_stb <= 1'b0;
      a            <= 32'd0;
      b            <= 32'd0;
      z            <= 32'd0;
      a_m          <= 27'd0;
      b_m          <= 27'd0;
      z_m          <= 27'd0;
      a_e          <= 10'sd0;
      b_e          <= 10'sd0;
      z_e          <= 10'sd0;
      a_s          <= 1'b0;
      b_s          <= 1'b0;
      z_s          <= 1'b0;
      sum          <= 28'd0;
    end else begin
      output_z_stb <= 1'b0;
      case (state)
        GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
            state       <= GET_B;
          end else begin
            input_a_ack <= 1'b1;
          end
        end
        GET_B: begin
          if (input_b_ack && input_b_stb) begin
            b           <= input_b;
            input_b_ack <= 1'b0;
            state       <= UNPACK;
          end else begin
            input_b_ack <= 1'b1;
          end
        end
        UNPACK: begin
          a_m   <= {fa.mant, 3'b000};
          b_m   <= {fb.mant, 3'b000};
          a_e   <= fa.exp;
          b_e   <= fb.exp;
          a_s   <= fa.sign;
          b_s   <= fb.sign;
          state <= SPECIAL;
        end
        SPECIAL: begin
          state <= PUT_Z;
          if (fa.is_nan || fb.is_nan)         z <= QNAN;
          else if (fa.is_inf)                 z <= (fb.is_inf && fa.sign != fb.sign) ? QNAN
                                                   : (POS_INF | {fa.sign, 31'd0});
          else if (fb.is_inf)                 z <= POS_INF | {fb.sign, 31'd0};
          else if (fa.is_zero && fb.is_zero)  z <= {fa.sign & fb.sign, 31'd0};
          else if (fa.is_zero)                z <= b;
          else if (fb.is_zero)                z <= a;
          else                                state <= ALIGN;
        end
        // Shifted-out bits collapse into the sticky position so rounding still sees them.
        ALIGN: begin
          if (a_e > b_e) begin
            b_e <= b_e + 10'sd1;
            b_m <= {1'b0, b_m[26:2], b_m[1] | b_m[0]};
          end else if (a_e < b_e) begin
            a_e <= a_e + 10'sd1;
            a_m <= {1'b0, a_m[26:2], a_m[1] | a_m[0]};
          end else begin
            state <= ADD_0;
          end
        end
        ADD_0: begin
          z_e   <= a_e;
          state <= ADD_1;
          if (a_s == b_s) begin
            sum <= {1'b0, a_m} + {1'b0, b_m};
            z_s <= a_s;
          end else if (a_m >= b_m) begin
            sum <= {1'b0, a_m - b_m};
            z_s <= a_s;
          end else begin
            sum <= {1'b0, b_m - a_m};
            z_s <= b_s;
          end
        end
        ADD_1: begin
          if (sum == 28'd0) begin
            z     <= 32'd0;
            state <= PUT_Z;
          end else if (sum[27]) begin
            z_m   <= {sum[27:2], sum[1] | sum[0]};
            z_e   <= z_e + 10'sd1;
            state <= NORM_1;
          end else begin
            z_m   <= sum[26:0];
            state <= NORM_1;
          end
        end
        NORM_1: begin
          if (!z_m[26] && z_e > E_MIN) begin
            z_m <= z_m << 1;
            z_e <= z_e - 10'sd1;
          end else begin
`ifdef FP32_ADDER_DENORM_EN
            state <= NORM_2;
`else
            state <= ROUND;
`endif
          end
        end
`ifdef FP32_ADDER_DENORM_EN
        NORM_2: begin
          if (z_e < E_MIN) begin
            z_e <= z_e + 10'sd1;
            z_m <= {1'b0, z_m[26:2], z_m[1] | z_m[0]};
          end else begin
            state <= ROUND;
          end
        end
`endif
        ROUND: begin
          if (z_m[2] && (z_m[1] | z_m[0] | z_m[3])) begin
            if (&z_m[26:3]) begin
              z_m[26:3] <= 24'h80_0000;
              z_e       <= z_e + 10'sd1;
            end else begin
              z_m[26:3] <= z_m[26:3] + 24'd1;
            end
          end
          state <= PACK;
        end
        PACK: begin
          z     <= z_packed;
          state <= PUT_Z;
        end
        PUT_Z: begin
          output_z     <= z;
          output_z_stb <= 1'b1;
          state        <= GET_A;
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_adder.sv
// Self-checking bench for fp32_adder: directed cases, handshake stall/abort, random vs exact model.
module tb_fp32_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b;
  logic        input_a_stb, input_b_stb;
  logic        input_a_ack, input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;

  int checks   = 0;
  int failures = 0;

  fp32_adder dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb)
  );

  always #5 clk = ~clk;

  // Reference: exact sum as a wide integer in units of 2^-149, then one correct RNE rounding.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]   ea, eb;
    logic [22:0]  fa, fb;
    logic         sa, sb, sz, found;
    logic [23:0]  ma24, mb24;
    logic [319:0] ma, mb, mag, keep, rem, half;
    logic [31:0]  r;
    int           p, sh, e;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return 32'h7FC0_0000;
    if (ea == 8'hFF && eb == 8'hFF) return (sa != sb) ? 32'h7FC0_0000 : {sa, 31'h7F80_0000};
    if (ea == 8'hFF) return {sa, 31'h7F80_0000};
    if (eb == 8'hFF) return {sb, 31'h7F80_0000};
`ifndef FP32_ADDER_DENORM_EN
    if (ea == 8'd0) fa = 23'd0;
    if (eb == 8'd0) fb = 23'd0;
`endif
    ma24 = {ea != 8'd0, fa};
    mb24 = {eb != 8'd0, fb};
    ma = 320'(ma24) << ((ea == 8'd0) ? 0 : int'(ea) - 1);
    mb = 320'(mb24) << ((eb == 8'd0) ? 0 : int'(eb) - 1);
    if (ma == 0 && mb == 0) return {sa & sb, 31'd0};
    if (sa == sb)      begin mag = ma + mb; sz = sa; end
    else if (ma >= mb) begin mag = ma - mb; sz = sa; end
    else               begin mag = mb - ma; sz = sb; end
    if (mag == 0) return 32'd0;
    p = 0; found = 1'b0;
    for (int i = 319; i >= 0; i--) begin
      if (!found && mag[i]) begin p = i; found = 1'b1; end
    end
    if (p <= 23) begin
      r = {sz, mag[30:0]};
    end else begin
      sh   = p - 23;
      keep = mag >> sh;
      rem  = mag - (keep << sh);
      half = 320'(1) << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
      if (keep[24]) begin keep = keep >> 1; sh = sh + 1; end
      e = sh + 1;
      if (e >= 255) return {sz, 31'h7F80_0000};
      r = {sz, e[7:0], keep[22:0]};
    end
`ifndef FP32_ADDER_DENORM_EN
    if (r[30:23] == 8'd0) r = {sz, 31'd0};
`endif
    return r;
  endfunction

  function automatic logic [31:0] rand_operand(input int base);
    logic s;
    int   e;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 19))
      0: return {s, 31'd0};
      1: return {s, 8'hFF, 23'd0};
      2: return {s, 8'hFF, 23'h40_0000 | 23'($urandom_range(0, 1023))};
      3: return {s, 8'd0, 23'($urandom)};
      4: e = int'($urandom_range(250, 254));
      default: begin
        e = base + int'($urandom_range(0, 40)) - 20;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
      end
    endcase
    return {s, e[7:0], 23'($urandom)};
  endfunction

  // Driver only: hands over a then b, waits for the result strobe. Call at a negedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] z, output bit ok);
    int n;
    ok = 1'b0;
    z  = 32'hxxxx_xxxx;
    input_a = a; input_a_stb = 1'b1; n = 0;
    while (!input_a_ack && n < 50) begin @(negedge clk); n++; end
    if (!input_a_ack) begin input_a_stb = 1'b0; return; end
    @(negedge clk); input_a_stb = 1'b0;
    input_b = b; input_b_stb = 1'b1; n = 0;
    while (!input_b_ack && n < 50) begin @(negedge clk); n++; end
    if (!input_b_ack) begin input_b_stb = 1'b0; return; end
    @(negedge clk); input_b_stb = 1'b0;
    n = 0;
    while (!output_z_stb && n < 600) begin @(negedge clk); n++; end
    if (output_z_stb) begin z = output_z; ok = 1'b1; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (input_a_ack !== 1'b0 || input_b_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_acks a_ack=%b b_ack=%b expected 0 0", input_a_ack, input_b_ack);
    end
    checks++;
    if (output_z !== 32'd0 || output_z_stb !== 1'b0) begin
      failures++;
      $display("FAIL reset_out z=%h stb=%b expected 00000000 0", output_z, output_z_stb);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (input_a_ack !== 1'b1 || input_b_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_release a_ack=%b b_ack=%b expected 1 0", input_a_ack, input_b_ack);
    end
  endtask

  task automatic test_directed();
    logic [31:0] da[11], db[11], dz[11];
    logic [31:0] z, denorm_exp;
    bit ok;
`ifdef FP32_ADDER_DENORM_EN
    denorm_exp = 32'h0000_0002;
`else
    denorm_exp = 32'h0000_0000;
`endif
    da = '{32'h3F80_0000, 32'h3F80_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7F80_0000,
           32'h0000_0001, 32'hFF81_2345, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h0000_0000,
           32'h3F80_0001};
    db = '{32'h4000_0000, 32'hBF80_0000, 32'h8000_0000, 32'hFF80_0000, 32'h3F80_0000,
           32'h0000_0001, 32'h3F80_0000, 32'h7F7F_FFFF, 32'h3380_0000, 32'hC049_0FDB,
           32'h3380_0000};
    dz = '{32'h4040_0000, 32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h7F80_0000,
           denorm_exp,    32'h7FC0_0000, 32'h7F80_0000, 32'h3F80_0000, 32'hC049_0FDB,
           32'h3F80_0002};
    for (int i = 0; i < 11; i++) begin
      run_op(da[i], db[i], z, ok);
      checks++;
      if (!ok || z !== dz[i]) begin
        failures++;
        $display("FAIL directed[%0d] a=%h b=%h got=%h expected=%h done=%0d",
                 i, da[i], db[i], z, dz[i], ok);
      end
      @(negedge clk);
      checks++;
      if (output_z_stb !== 1'b0) begin
        failures++;
        $display("FAIL stb_width[%0d] stb=%b one cycle later, expected 0", i, output_z_stb);
      end
    end
  endtask

  task automatic test_stall_abort();
    int n, seen;
    logic [31:0] z;
    bit ok;
    input_a = 32'h3F80_0000; input_a_stb = 1'b1; n = 0;
    while (!input_a_ack && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); input_a_stb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (input_b_ack !== 1'b1 || input_a_ack !== 1'b0 || output_z_stb !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d] b_ack=%b a_ack=%b stb=%b expected 1 0 0",
                 i, input_b_ack, input_a_ack, output_z_stb);
      end
    end
    input_b = 32'h4B00_0000; input_b_stb = 1'b1;
    @(negedge clk); input_b_stb = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (input_a_ack !== 1'b0 || input_b_ack !== 1'b0 || output_z !== 32'd0 || output_z_stb !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear a_ack=%b b_ack=%b z=%h stb=%b expected 0 0 00000000 0",
               input_a_ack, input_b_ack, output_z, output_z_stb);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (input_a_ack !== 1'b1) begin
      failures++;
      $display("FAIL abort_release a_ack=%b expected 1", input_a_ack);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (output_z_stb) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_stb strobes=%0d expected 0", seen);
    end
    run_op(32'h4000_0000, 32'h4040_0000, z, ok);
    checks++;
    if (!ok || z !== 32'h40A0_0000) begin
      failures++;
      $display("FAIL abort_recover got=%h expected=40a00000 done=%0d", z, ok);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int base;
      logic [31:0] a, b, z, expz;
      bit ok;
      base = int'($urandom_range(1, 254));
      a = rand_operand(base);
      b = rand_operand(base);
      if ($urandom_range(0, 7) == 0) b = a ^ 32'h8000_0000 ^ 32'($urandom_range(0, 3));
      expz = ref_add(a, b);
      run_op(a, b, z, ok);
      checks++;
      if (!ok || z !== expz) begin
        failures++;
        $display("FAIL random[%0d] a=%h b=%h got=%h expected=%h done=%0d", i, a, b, z, expz, ok);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    input_a = 32'd0; input_b = 32'd0;
    input_a_stb = 1'b0; input_b_stb = 1'b0;
    test_reset();
    test_directed();
    test_stall_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
